// File: rtl/bist_pkg.sv
// Shared definitions for the 4-bit BIST datapath: controller states and the
// seed / golden-signature constants also used by the TPG and MISR.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  localparam int                     WIDTH_DEF      = 4;
  localparam logic [WIDTH_DEF-1:0]   SEED_DEF       = 4'h1;
  localparam logic [WIDTH_DEF-1:0]   GOLDEN_SIG_DEF = 4'hA;

endpackage

// File: rtl/bist_delay_line.sv
// DEPTH-stage shift register that aligns misr_en with the CUT pipeline.
// A depth of 0 is a straight pass-through of the registered tpg_en.
module bist_delay_line #(
  parameter int DEPTH = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, rst_i, clr_i};
    assign q_o       = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sr_q <= '0;
      end else if (clr_i) begin
        sr_q <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the TPG, clears the MISR, runs NUM_PATTERNS patterns
// (plus CUT_LATENCY flush cycles) and latches a pass/fail verdict.
module bist_controller
  import bist_pkg::*;
#(
  parameter int               WIDTH        = WIDTH_DEF,
  parameter int               NUM_PATTERNS = 15,
  parameter int               CUT_LATENCY  = 0,
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = WIDTH'(GOLDEN_SIG_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  signature,
  output logic              test_mode,
  output logic              tpg_load,
  output logic              tpg_en,
  output logic              misr_clr,
  output logic              misr_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output bist_state_e       dbg_state
);

  localparam int            TOTAL    = NUM_PATTERNS + CUT_LATENCY;
  localparam int            CW       = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_K   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] TPG_LAST = CW'(NUM_PATTERNS - 1);

  bist_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          test_mode_q, tpg_load_q, tpg_en_q, misr_clr_q;
  logic          busy_q, done_q, pass_q, fail_q;
  logic          dly_clr;

  // An abort can only land while busy; IDLE and DONE ignore it so start wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      test_mode_q <= 1'b0;
      tpg_load_q  <= 1'b0;
      tpg_en_q    <= 1'b0;
      misr_clr_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (abort && busy_q) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      test_mode_q <= 1'b0;
      tpg_load_q  <= 1'b0;
      tpg_en_q    <= 1'b0;
      misr_clr_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            test_mode_q <= 1'b1;
            tpg_load_q  <= 1'b1;
            misr_clr_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
          end
        end
        ST_INIT: begin
          state_q    <= ST_RUN;
          cnt_q      <= '0;
          tpg_load_q <= 1'b0;
          misr_clr_q <= 1'b0;
          tpg_en_q   <= 1'b1;
        end
        ST_RUN: begin
          if (cnt_q == LAST_K) begin
            state_q  <= ST_COMPARE;
            tpg_en_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            tpg_en_q <= (cnt_q < TPG_LAST);
          end
        end
        ST_COMPARE: begin
          state_q     <= ST_DONE;
          test_mode_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          pass_q      <= (signature == GOLDEN_SIG);
          fail_q      <= (signature != GOLDEN_SIG);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The flush stages must empty on abort so misr_en drops with everything else.
  assign dly_clr = abort && busy_q;

  bist_delay_line #(
    .DEPTH (CUT_LATENCY)
  ) u_misr_dly (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (dly_clr),
    .d_i   (tpg_en_q),
    .q_o   (misr_en)
  );

  assign test_mode = test_mode_q;
  assign tpg_load  = tpg_load_q;
  assign tpg_en    = tpg_en_q;
  assign misr_clr  = misr_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: two instances (CUT latency 0 and 2) share stimulus
// and are checked against a phase-count reference model and a verdict queue.
module tb_bist_controller;
  import bist_pkg::*;

  localparam int         NP   = 8;
  localparam int         LAT0 = 0;
  localparam int         LAT2 = 2;
  localparam logic [3:0] GOLD = 4'hA;

  // {test_mode, tpg_load, tpg_en, misr_clr, misr_en, busy, done, pass, fail}
  localparam logic [8:0] E_IDLE = 9'b000000000;
  localparam logic [8:0] E_INIT = 9'b110101000;
  localparam logic [8:0] E_RUN  = 9'b101011000;
  localparam logic [8:0] E_TPG  = 9'b101001000;
  localparam logic [8:0] E_MSR  = 9'b100011000;
  localparam logic [8:0] E_CMP  = 9'b100001000;
  localparam logic [8:0] E_PASS = 9'b000000110;
  localparam logic [8:0] E_FAIL = 9'b000000101;

  typedef struct {
    logic       s;
    logic       a;
    logic [3:0] g;
    logic [8:0] e0;
    logic [8:0] e2;
  } vec_t;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] sig = GOLD;

  always #5 clk = ~clk;

  logic        tm0, tl0, te0, mc0, me0, bz0, dn0, ps0, fl0;
  logic        tm2, tl2, te2, mc2, me2, bz2, dn2, ps2, fl2;
  bist_state_e st0, st2;
  logic [8:0]  out0, out2;
  logic [11:0] v0, v2;

  assign out0 = {tm0, tl0, te0, mc0, me0, bz0, dn0, ps0, fl0};
  assign out2 = {tm2, tl2, te2, mc2, me2, bz2, dn2, ps2, fl2};
  assign v0   = {st0, out0};
  assign v2   = {st2, out2};

  bist_controller #(.WIDTH(4), .NUM_PATTERNS(NP), .CUT_LATENCY(LAT0), .GOLDEN_SIG(GOLD)) u_dut0 (
    .clock(clk), .reset(rst), .start(start), .abort(abort), .signature(sig),
    .test_mode(tm0), .tpg_load(tl0), .tpg_en(te0), .misr_clr(mc0), .misr_en(me0),
    .busy(bz0), .done(dn0), .pass(ps0), .fail(fl0), .dbg_state(st0)
  );

  bist_controller #(.WIDTH(4), .NUM_PATTERNS(NP), .CUT_LATENCY(LAT2), .GOLDEN_SIG(GOLD)) u_dut2 (
    .clock(clk), .reset(rst), .start(start), .abort(abort), .signature(sig),
    .test_mode(tm2), .tpg_load(tl2), .tpg_en(te2), .misr_clr(mc2), .misr_en(me2),
    .busy(bz2), .done(dn2), .pass(ps2), .fail(fl2), .dbg_state(st2)
  );

  // ---------------- reference model ----------------
  // Phase 0 = not testing; 1 = INIT; 2..NP+L+1 = RUN; NP+L+2 = COMPARE.
  int         m_ph   [2];
  bit         m_done [2];
  bit         m_pass [2];
  logic [1:0] exp_q0 [$];
  logic [1:0] exp_q2 [$];

  function automatic int lat_of(input int c);
    return (c == 0) ? LAT0 : LAT2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_ph[c]   <= 0;
        m_done[c] <= 1'b0;
        m_pass[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_ph[c] != 0) begin
          if (abort) begin
            m_ph[c] <= 0;
          end else if (m_ph[c] == NP + lat_of(c) + 2) begin
            m_ph[c]   <= 0;
            m_done[c] <= 1'b1;
            m_pass[c] <= (sig == GOLD);
            if (c == 0) exp_q0.push_back((sig == GOLD) ? 2'b10 : 2'b01);
            else        exp_q2.push_back((sig == GOLD) ? 2'b10 : 2'b01);
          end else begin
            m_ph[c] <= m_ph[c] + 1;
          end
        end else if (start) begin
          m_ph[c]   <= 1;
          m_done[c] <= 1'b0;
          m_pass[c] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [11:0] exp_vec(input int c);
    int          ph, l, tot;
    logic [8:0]  b;
    bist_state_e st;
    ph  = m_ph[c];
    l   = lat_of(c);
    tot = NP + l + 2;
    b = {ph >= 1, ph == 1, (ph >= 2) && (ph <= NP + 1), ph == 1,
         (ph >= l + 2) && (ph <= NP + l + 1), ph >= 1,
         m_done[c], m_done[c] && m_pass[c], m_done[c] && !m_pass[c]};
    if (ph == 0)        st = m_done[c] ? ST_DONE : ST_IDLE;
    else if (ph == 1)   st = ST_INIT;
    else if (ph == tot) st = ST_COMPARE;
    else                st = ST_RUN;
    return {st, b};
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit dn0_prev = 1'b0;
  bit dn2_prev = 1'b0;

  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    cmp("model0", v0, exp_vec(0));
    cmp("model2", v2, exp_vec(1));
    if (dn0 && !dn0_prev) begin
      if (exp_q0.size() == 0) cmp("verdict0_unexpected", {10'd0, ps0, fl0}, 12'hfff);
      else                    cmp("verdict0", {10'd0, ps0, fl0}, {10'd0, exp_q0.pop_front()});
    end
    if (dn2 && !dn2_prev) begin
      if (exp_q2.size() == 0) cmp("verdict2_unexpected", {10'd0, ps2, fl2}, 12'hfff);
      else                    cmp("verdict2", {10'd0, ps2, fl2}, {10'd0, exp_q2.pop_front()});
    end
    dn0_prev = dn0;
    dn2_prev = dn2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic s, input logic a, input logic [3:0] g);
    @(posedge clk);
    #1;
    start = s;
    abort = a;
    sig   = g;
    @(negedge clk);
    check_cycle();
  endtask

  // Start pulse from IDLE/DONE; the second tick observes INIT.
  task automatic start_test(input logic [3:0] g, input logic with_abort);
    tick(1'b1, with_abort, g);
    tick(1'b0, 1'b0, g);
    cmp("init0", {3'd0, out0}, {3'd0, E_INIT});
    cmp("init2", {3'd0, out2}, {3'd0, E_INIT});
  endtask

  task automatic run_until_done(input logic [3:0] g, input bit poke,
                                output int n_te, output int n_me);
    int cyc;
    n_te = 0;
    n_me = 0;
    cyc  = 0;
    while (!(dn0 && dn2) && cyc < 40) begin
      tick(poke && bz0 && bz2 && ($urandom_range(0, 1) == 1), 1'b0, g);
      cyc++;
      n_te += int'(te0);
      n_me += int'(me2);
    end
    if (!(dn0 && dn2)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got done0=%0b done2=%0b, expected both 1 within 40 cycles", dn0, dn2);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vec [16];
  int   nte, nme;

  initial begin
    for (int i = 0; i < 16; i++) vec[i] = '{1'b0, 1'b0, GOLD, E_IDLE, E_IDLE};
    vec[0].s = 1'b1;
    vec[1].e0 = E_INIT;
    vec[1].e2 = E_INIT;
    for (int i = 2; i <= 9; i++) begin
      vec[i].e0 = E_RUN;
      vec[i].e2 = (i < 4) ? E_TPG : E_RUN;
    end
    vec[10].e0 = E_CMP;  vec[10].e2 = E_MSR;
    vec[11].e0 = E_PASS; vec[11].e2 = E_MSR;
    vec[12].e0 = E_PASS; vec[12].e2 = E_CMP;
    for (int i = 13; i < 16; i++) begin
      vec[i].e0 = E_PASS;
      vec[i].e2 = E_PASS;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("reset0", v0, {ST_IDLE, E_IDLE});
    cmp("reset2", v2, {ST_IDLE, E_IDLE});

    // Pass flow and latency flow, cycle by cycle.
    for (int i = 0; i < 16; i++) begin
      tick(vec[i].s, vec[i].a, vec[i].g);
      cmp($sformatf("tbl0_row%0d", i), {3'd0, out0}, {3'd0, vec[i].e0});
      cmp($sformatf("tbl2_row%0d", i), {3'd0, out2}, {3'd0, vec[i].e2});
    end
    repeat (20) begin
      tick(1'b0, 1'b0, GOLD);
      cmp("pass_hold0", {3'd0, out0}, {3'd0, E_PASS});
    end

    // Fail flow, started from DONE.
    start_test(4'h5, 1'b0);
    run_until_done(4'h5, 1'b0, nte, nme);
    cmp("fail0", {3'd0, out0}, {3'd0, E_FAIL});
    cmp("fail2", {3'd0, out2}, {3'd0, E_FAIL});

    // Abort in the 4th RUN cycle, then a clean run.
    start_test(GOLD, 1'b0);
    tick(1'b0, 1'b0, GOLD);
    tick(1'b0, 1'b0, GOLD);
    tick(1'b0, 1'b0, GOLD);
    tick(1'b0, 1'b1, GOLD);
    cmp("abort_run4", {3'd0, out0}, {3'd0, E_RUN});
    tick(1'b0, 1'b0, GOLD);
    cmp("abort_idle0", v0, {ST_IDLE, E_IDLE});
    cmp("abort_idle2", v2, {ST_IDLE, E_IDLE});
    repeat (5) tick(1'b0, 1'b0, GOLD);
    cmp("abort_nodone", {10'd0, dn0, dn2}, 12'd0);
    start_test(GOLD, 1'b0);
    run_until_done(GOLD, 1'b0, nte, nme);
    cmp("post_abort_pass", {3'd0, out0}, {3'd0, E_PASS});
    cmp("post_abort_tpg_cnt", 12'(nte), 12'(NP));
    cmp("post_abort_misr_cnt", 12'(nme), 12'(NP));

    // Start pulses during RUN are ignored.
    start_test(4'h3, 1'b0);
    run_until_done(4'h3, 1'b1, nte, nme);
    cmp("start_in_run_tpg_cnt", 12'(nte), 12'(NP));
    cmp("start_in_run_misr_cnt", 12'(nme), 12'(NP));
    cmp("start_in_run_fail", {3'd0, out2}, {3'd0, E_FAIL});

    // Start and abort together in DONE: start wins and clears the verdict.
    start_test(GOLD, 1'b1);
    cmp("start_abort_state", {9'd0, st0}, {9'd0, ST_INIT});

    // Asynchronous reset mid-RUN, checked before the next clock edge.
    repeat (3) tick(1'b0, 1'b0, GOLD);
    #2 rst = 1'b1;
    #1;
    cmp("async_rst0", v0, {ST_IDLE, E_IDLE});
    cmp("async_rst2", v2, {ST_IDLE, E_IDLE});
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1'b0, 1'b0, GOLD);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
           ($urandom_range(0, 1) == 1) ? GOLD : 4'($urandom_range(0, 15)));
    end
    repeat (20) tick(1'b0, 1'b0, GOLD);
    cmp("sb_left0", 12'(exp_q0.size()), 12'd0);
    cmp("sb_left2", 12'(exp_q2.size()), 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Top-level BIST sequencer for the 4-bit test datapath: LFSR test-pattern generator (TPG) -> circuit under test (CUT) -> MISR output-response analyser.
- On a start request it seeds the TPG, clears the MISR and switches the CUT inputs to test mode.
- It then runs a fixed number of patterns, compensating for CUT pipeline latency.
- Finally it compares the MISR signature against a golden value and holds a pass/fail verdict.

Parameters:
- WIDTH, 4, datapath and signature width
- NUM_PATTERNS, 15, patterns applied per test; legal range 1..2^16-1
- CUT_LATENCY, 0, register stages between the TPG output and the MISR input; legal range 0..7
- GOLDEN_SIG, 4'hA, expected final signature (WIDTH bits)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a test
- abort  in  1  cancels a test in progress
- signature  in  WIDTH  current MISR output
- test_mode  out  1  selects TPG patterns onto the CUT inputs
- tpg_load  out  1  loads the seed into the TPG
- tpg_en  out  1  advances the TPG one step
- misr_clr  out  1  synchronous clear of the MISR
- misr_en  out  1  MISR captures the CUT response this cycle
- busy  out  1  test in progress (INIT, RUN or COMPARE)
- done  out  1  verdict valid
- pass  out  1  signature matched GOLDEN_SIG
- fail  out  1  signature mismatched

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Every output is 0.
  - Pattern and latency counters are 0.
- All outputs are registered (Moore); values below are for the cycle the FSM is in that state.
- States: IDLE, INIT, RUN, COMPARE, DONE.
- IDLE:
  - All outputs 0.
  - start=1 -> INIT.
- INIT (exactly 1 cycle):
  - test_mode=1, tpg_load=1, misr_clr=1, busy=1.
  - pass, fail and done are cleared.
  - Next state is RUN.
- RUN (NUM_PATTERNS+CUT_LATENCY cycles):
  - Run-cycle counter k runs 0..NUM_PATTERNS+CUT_LATENCY-1.
  - test_mode=1 and busy=1 throughout.
  - tpg_en=1 for k < NUM_PATTERNS.
  - misr_en=1 for CUT_LATENCY <= k < NUM_PATTERNS+CUT_LATENCY.
  - Net effect: misr_en is tpg_en delayed by CUT_LATENCY cycles, and both are high for exactly NUM_PATTERNS cycles.
  - After the last k, next state is COMPARE.
- COMPARE (1 cycle):
  - test_mode=1, busy=1, tpg_en=0, misr_en=0.
  - signature is sampled at the end of this cycle.
  - Next state is DONE with pass=(signature==GOLDEN_SIG) and fail=~pass.
- DONE:
  - done=1; pass and fail are held; test_mode=0, busy=0.
  - start=1 -> INIT, which clears the verdict.
  - Otherwise the FSM stays in DONE indefinitely.
- start while busy is ignored; it is neither queued nor restarts the test.
- abort:
  - In INIT, RUN or COMPARE, the next state is IDLE and all outputs go to 0; done is never asserted.
  - In IDLE or DONE, abort has no effect.
  - abort and start in the same IDLE or DONE cycle: start wins.
- Exactly one of pass and fail is high whenever done=1; both are 0 otherwise.
- Counter width is clog2(NUM_PATTERNS+CUT_LATENCY+1) bits. Counters never wrap within a test and are cleared in INIT.
- Reset asserted mid-test takes effect immediately, without waiting for a clock edge, and the controller returns to IDLE.

Decomposition:
- Shared package bist_pkg holds:
  - the state enumeration (IDLE, INIT, RUN, COMPARE, DONE);
  - the default WIDTH;
  - the default seed and GOLDEN_SIG constants shared with the TPG and MISR.
- One sub-module is natural: bist_delay_line, a CUT_LATENCY-deep shift register that generates misr_en from tpg_en. A depth of 0 is a pass-through.
- The FSM, counters and comparator stay in bist_controller.

Test Plan:
- Reset check: assert reset asynchronously between clock edges mid-RUN -> all outputs 0 before the next edge; FSM in IDLE.
- Pass flow (NUM_PATTERNS=8, CUT_LATENCY=0; start sampled at edge 0; bench holds signature=4'hA):
  - INIT in cycle 1, with tpg_load=1 and misr_clr=1;
  - tpg_en=misr_en=1 in cycles 2-9 (exactly 8 cycles);
  - COMPARE in cycle 10;
  - from cycle 11: done=1, pass=1, fail=0, busy=0, held for 20 cycles.
- Fail flow: same stimulus with signature=4'h5 at COMPARE -> done=1, pass=0, fail=1.
- Latency flow (CUT_LATENCY=2, NUM_PATTERNS=8):
  - tpg_en high in cycles 2-9;
  - misr_en high in cycles 4-11;
  - COMPARE in cycle 12;
  - done in cycle 13.
- Abort: pulse abort during the 4th RUN cycle -> next cycle IDLE, all controls 0, done stays 0. A following start produces a complete 8-pattern run with the correct verdict.
- Start handling:
  - start pulses during RUN are ignored; the run length is unchanged.
  - start in DONE re-enters INIT and clears pass/fail.
  - start and abort in the same DONE cycle -> INIT.
